// File: rtl/audio_pkg.sv
// Constants and arithmetic helpers shared by the IMDCT back end, the overlap-add stage and the PCM sink.
package audio_pkg;
    localparam int N         = 512;
    localparam int AW        = 9;
    localparam int DW        = 32;
    localparam int WIN_W     = 16;
    localparam int OUT_SHIFT = 15;
    localparam int PCM_W     = 16;
    localparam int PROD_W    = 48;
    localparam int HALF      = N / 2;

    localparam logic [WIN_W-1:0] WIN_UNITY = 16'h7FFF;

    localparam logic signed [PROD_W-1:0] PCM_MAX = 48'sd32767;
    localparam logic signed [PROD_W-1:0] PCM_MIN = -48'sd32768;
    localparam logic signed [PROD_W-1:0] S32_MAX = 48'sd2147483647;
    localparam logic signed [PROD_W-1:0] S32_MIN = -48'sd2147483648;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RDA, ST_WTA, ST_OUT, ST_RDB, ST_WTB, ST_WRB, ST_DONE
    } ola_state_t;

    function automatic logic [31:0] byte_addr(input logic [AW-1:0] idx);
        return {{(32 - AW - 2){1'b0}}, idx, 2'b00};
    endfunction

    // Full-precision y*w, then scaled back by the Q1.15 window shift.
    function automatic logic signed [PROD_W-1:0] win_mul(input logic signed [DW-1:0] y,
                                                         input logic signed [WIN_W-1:0] w);
        logic signed [PROD_W-1:0] prod;
        prod = $signed({{(PROD_W-DW){y[DW-1]}}, y}) * $signed({{(PROD_W-WIN_W){w[WIN_W-1]}}, w});
        return prod >>> OUT_SHIFT;
    endfunction

    function automatic logic signed [PCM_W-1:0] sat16(input logic signed [PROD_W-1:0] x);
        if (x > PCM_MAX)      return 16'sh7FFF;
        else if (x < PCM_MIN) return 16'sh8000;
        else                  return x[PCM_W-1:0];
    endfunction

    function automatic logic signed [DW-1:0] sat32(input logic signed [PROD_W-1:0] x);
        if (x > S32_MAX)      return 32'sh7FFF_FFFF;
        else if (x < S32_MIN) return 32'sh8000_0000;
        else                  return x[DW-1:0];
    endfunction
endpackage

// File: rtl/ola_window_rom.sv
// Combinational window coefficient lookup; the table is a parameter so the owning block picks the window shape.
module ola_window_rom
    import audio_pkg::*;
#(
    parameter logic [N-1:0][WIN_W-1:0] WIN_TABLE = {N{WIN_UNITY}}
) (
    input  logic [AW-1:0]           idx,
    output logic signed [WIN_W-1:0] w
);
    assign w = WIN_TABLE[idx];
endmodule

// File: rtl/imdct_overlap_add.sv
// Windows one IMDCT frame from BRAM, overlap-adds the first half with saved history into 16-bit PCM,
// and keeps the windowed second half as history for the next frame.
module imdct_overlap_add
    import audio_pkg::*;
#(
    parameter logic [N-1:0][WIN_W-1:0] WIN_TABLE = {N{WIN_UNITY}}
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hist_clr,
    output logic [31:0]      bram_addr,
    output logic             bram_en,
    input  logic [DW-1:0]    bram_dout,
    output logic [PCM_W-1:0] pcm_data,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             busy,
    output logic             done
);
    ola_state_t               state;
    logic [AW-1:0]            idx;
    logic [AW-1:0]            idx_nxt;
    logic [AW-2:0]            hidx;
    logic signed [DW-1:0]     y_q;
    logic signed [WIN_W-1:0]  w;
    logic signed [PROD_W-1:0] p_a;
    logic signed [PROD_W-1:0] p_b;
    logic [PCM_W-1:0]         pcm_nxt;
    logic signed [DW-1:0]     hist_rd;
    logic signed [DW-1:0]     hist_wr;

    // Per-entry valid flags give an instant clear without sweeping the storage array.
    logic [HALF-1:0]          hist_vld;
    logic signed [DW-1:0]     hist_mem [HALF];

    ola_window_rom #(.WIN_TABLE(WIN_TABLE)) u_win (
        .idx (idx),
        .w   (w)
    );

    assign idx_nxt = idx + AW'(1);
    assign hidx    = idx[AW-2:0];
    assign hist_rd = hist_vld[hidx] ? hist_mem[hidx] : '0;
    assign p_a     = win_mul($signed(bram_dout), w);
    assign pcm_nxt = sat16(p_a + $signed({{(PROD_W-DW){hist_rd[DW-1]}}, hist_rd}));
    assign p_b     = win_mul(y_q, w);
    assign hist_wr = sat32(p_b);

    always_ff @(posedge clk_in) begin
        if (state == ST_WRB) hist_mem[hidx] <= hist_wr;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            y_q       <= '0;
            hist_vld  <= '0;
            bram_addr <= '0;
            bram_en   <= 1'b0;
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hist_clr) hist_vld <= '0;
                    if (start) begin
                        state     <= ST_RDA;
                        idx       <= '0;
                        busy      <= 1'b1;
                        bram_en   <= 1'b1;
                        bram_addr <= byte_addr('0);
                    end
                end
                ST_RDA: begin
                    bram_en <= 1'b0;
                    state   <= ST_WTA;
                end
                // pcm_data is formed straight from the BRAM word so it is ready on entry to OUT.
                ST_WTA: begin
                    y_q       <= $signed(bram_dout);
                    pcm_data  <= pcm_nxt;
                    pcm_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (pcm_ready) begin
                        pcm_valid <= 1'b0;
                        idx       <= idx_nxt;
                        bram_en   <= 1'b1;
                        bram_addr <= byte_addr(idx_nxt);
                        state     <= (idx_nxt == AW'(HALF)) ? ST_RDB : ST_RDA;
                    end
                end
                ST_RDB: begin
                    bram_en <= 1'b0;
                    state   <= ST_WTB;
                end
                ST_WTB: begin
                    y_q   <= $signed(bram_dout);
                    state <= ST_WRB;
                end
                ST_WRB: begin
                    hist_vld[hidx] <= 1'b1;
                    idx            <= idx_nxt;
                    if (idx_nxt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= ST_RDB;
                        bram_en   <= 1'b1;
                        bram_addr <= byte_addr(idx_nxt);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imdct_overlap_add.sv
// Directed/random frames against an arithmetic overlap-add model with a synchronous BRAM model.
module tb_imdct_overlap_add;
    import audio_pkg::*;

    localparam int NS = N;
    localparam int HN = N / 2;

    function automatic logic [15:0] win_val(input int i);
        case (i % 8)
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h4000;
            3:       return 16'h0000;
            default: return 16'((i * 40503 + 12345) % 65536);
        endcase
    endfunction

    function automatic logic [NS-1:0][15:0] build_win();
        logic [NS-1:0][15:0] t;
        for (int i = 0; i < NS; i++) t[i] = win_val(i);
        return t;
    endfunction

    localparam logic [NS-1:0][15:0] TB_WIN = build_win();

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             start;
    logic             hist_clr;
    logic [31:0]      bram_addr;
    logic             bram_en;
    logic [DW-1:0]    bram_dout = '0;
    logic [PCM_W-1:0] pcm_data;
    logic             pcm_valid;
    logic             pcm_ready;
    logic             busy;
    logic             done;

    logic [31:0] mem [NS];
    longint      model_hist [HN];
    integer      exp_pcm [HN];
    int          n_pass = 0;
    int          n_total = 0;

    imdct_overlap_add #(.WIN_TABLE(TB_WIN)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .hist_clr  (hist_clr),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_dout (bram_dout),
        .pcm_data  (pcm_data),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) if (bram_en) bram_dout <= mem[bram_addr[10:2]];

    task automatic chk(input string tag, input integer obs, input integer expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint windowed(input int n);
        longint y;
        longint w;
        y = longint'($signed(mem[n]));
        w = longint'($signed(TB_WIN[n]));
        return (y * w) >>> 15;
    endfunction

    task automatic model_frame();
        for (int n = 0; n < HN; n++)
            exp_pcm[n] = int'(clamp(windowed(n) + model_hist[n], -64'sd32768, 64'sd32767));
        for (int n = HN; n < NS; n++)
            model_hist[n - HN] = clamp(windowed(n), -64'sd2147483648, 64'sd2147483647);
    endtask

    task automatic zero_hist();
        for (int i = 0; i < HN; i++) model_hist[i] = 0;
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int n = 0; n < NS; n++) mem[n] = v;
    endtask

    task automatic fill_random();
        for (int n = 0; n < NS; n++) mem[n] = $signed($urandom) >>> $urandom_range(0, 20);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_pcm_data"},  32'(pcm_data), 0);
        chk({tag, "_pcm_valid"}, 32'(pcm_valid), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_done"},      32'(done), 0);
        chk({tag, "_bram_en"},   32'(bram_en), 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
    endtask

    task automatic idle_clear();
        @(negedge clk_in);
        hist_clr = 1'b1;
        @(negedge clk_in);
        hist_clr = 1'b0;
        zero_hist();
    endtask

    // ready_pct: chance of pcm_ready per cycle; inject_at: sample index for a stray start+hist_clr;
    // abort_at: sample index for a mid-frame reset; clr_with_start: hist_clr in the start cycle.
    task automatic run_frame(input int ready_pct, input int inject_at, input int abort_at,
                             input bit clr_with_start);
        int          k;
        int          reads;
        bit          held;
        bit          got_done;
        bit          injected;
        logic [15:0] held_data;
        if (clr_with_start) zero_hist();
        model_frame();
        @(negedge clk_in);
        start    = 1'b1;
        hist_clr = clr_with_start;
        @(negedge clk_in);
        start    = 1'b0;
        hist_clr = 1'b0;
        k = 0; reads = 0; held = 0; got_done = 0; injected = 0;
        for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
            if (abort_at >= 0 && k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_outputs_zero("abort");
                zero_hist();
                @(negedge clk_in);
                rst_n     = 1'b1;
                pcm_ready = 1'b0;
                start     = 1'b0;
                hist_clr  = 1'b0;
                return;
            end
            if (bram_en) begin
                chk("bram_addr", bram_addr, reads * 4);
                reads++;
            end
            if (held) begin
                chk("hold_valid", 32'(pcm_valid), 1);
                chk("hold_data", 32'(pcm_data), 32'(held_data));
            end
            held = 0;
            chk("busy", 32'(busy), 1);
            if (done) got_done = 1;
            start     = 1'b0;
            hist_clr  = 1'b0;
            pcm_ready = (int'($urandom_range(0, 99)) < ready_pct);
            if (inject_at >= 0 && !injected && pcm_valid && k == inject_at) begin
                start    = 1'b1;
                hist_clr = 1'b1;
                injected = 1;
            end
            if (pcm_valid) begin
                if (pcm_ready) begin
                    if (k < HN) chk("pcm", 32'($signed(pcm_data)), exp_pcm[k]);
                    else        chk("extra_pcm", k, -1);
                    k++;
                end else begin
                    held      = 1;
                    held_data = pcm_data;
                end
            end
            @(negedge clk_in);
        end
        start    = 1'b0;
        hist_clr = 1'b0;
        chk("done_seen", 32'(got_done), 1);
        chk("samples", k, HN);
        chk("reads", reads, NS);
        @(negedge clk_in);
        pcm_ready = 1'b0;
        chk("done_pulse", 32'(done), 0);
        chk("busy_low", 32'(busy), 0);
        chk("valid_low", 32'(pcm_valid), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        hist_clr  = 1'b0;
        pcm_ready = 1'b0;
        zero_hist();
        repeat (3) @(negedge clk_in);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk_in);

        // Ramp frame from reset history.
        for (int n = 0; n < NS; n++) mem[n] = 32'(n) << 15;
        run_frame(100, -1, -1, 1'b0);

        // Constant 0x8000 twice: second frame accumulates and saturates.
        idle_clear();
        fill_const(32'h0000_8000);
        run_frame(100, -1, -1, 1'b0);
        run_frame(100, -1, -1, 1'b0);

        // Negative overflow.
        idle_clear();
        fill_const(32'hC000_0000);
        run_frame(100, -1, -1, 1'b0);

        // Most-negative sample against a -1.0 tap must saturate the history, then show through.
        fill_const(32'h8000_0000);
        run_frame(100, -1, -1, 1'b0);
        fill_const(32'h0000_0000);
        run_frame(100, -1, -1, 1'b0);

        // Back-pressure with sparse ready.
        fill_random();
        run_frame(25, -1, -1, 1'b0);

        // Stray start and hist_clr mid-frame are dropped.
        fill_random();
        run_frame(50, 100, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            chk("idle_after_stray_start", 32'(busy), 0);
        end

        // Clear in idle, then clear in the start cycle.
        idle_clear();
        fill_random();
        run_frame(70, -1, -1, 1'b0);
        fill_random();
        run_frame(100, -1, -1, 1'b1);

        // Mid-frame reset, then a fresh frame sees zero history.
        fill_random();
        run_frame(60, -1, 150, 1'b0);
        fill_random();
        run_frame(100, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
